// File: rtl/dc_ipu_filter_core_s0_mc.sv
// Filter core stage 0: per-texel weight multiply with round, shift and
// saturate, behind an elastic valid/ready pipeline of MUL_STAGES registers.
module dc_ipu_filter_core_s0_mc #(
    parameter int TAPS_Y                     = 4,
    parameter int TAPS_X                     = 4,
    parameter int CHANNELS                   = 3,
    parameter int WEIGHT_WIDTH               = 12,
    parameter int WEIGHT_FRACT_WIDTH         = 10,
    parameter int COLOR_WIDTH                = 8,
    parameter int WEIGHTED_COLOR_WIDTH       = 12,
    parameter int WEIGHTED_COLOR_FRACT_WIDTH = 2,
    parameter int MUL_STAGES                 = 2,
    parameter int ROUND                      = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic in_valid,
    output logic in_ready,
    input  logic signed [WEIGHT_WIDTH-1:0] weights_matrix [TAPS_Y][TAPS_X],
    input  logic [COLOR_WIDTH-1:0] texel_matrix [CHANNELS][TAPS_Y][TAPS_X],
    output logic out_valid,
    input  logic out_ready,
    output logic signed [WEIGHTED_COLOR_WIDTH-1:0]
        weighted_texel_matrix [CHANNELS][TAPS_Y][TAPS_X],
    output logic [CHANNELS-1:0] out_sat
);

    localparam int SHIFT = WEIGHT_FRACT_WIDTH - WEIGHTED_COLOR_FRACT_WIDTH;
    localparam int PW    = WEIGHT_WIDTH + COLOR_WIDTH + 1;
    localparam int OW    = WEIGHTED_COLOR_WIDTH;
    localparam int MS    = MUL_STAGES;
    localparam int BSH   = (SHIFT > 0) ? SHIFT - 1 : 0;

    // Rounding bias is half an output LSB, only when bits are discarded.
    localparam logic signed [PW:0] BIAS =
        ((ROUND != 0) && (SHIFT > 0)) ? ((PW + 1)'(1) << BSH) : '0;

    localparam logic signed [PW:0] SAT_MAX =
        {{(PW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [PW:0] SAT_MIN =
        {{(PW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};

    if (SHIFT < 0) begin : g_bad_shift
        $error("result fraction wider than weight fraction");
    end
    if ((MS < 1) || (MS > 4)) begin : g_bad_stages
        $error("MUL_STAGES must be 1..4");
    end
    if (OW > PW + 1) begin : g_bad_width
        $error("result wider than product");
    end

    logic [MS-1:0] valid;
    logic [MS-1:0] adv;
    logic [MS-1:0] load;
    logic [MS-1:0] up;
    logic          in_fire;
    logic          fin_load;

    logic signed [PW-1:0] prod    [CHANNELS][TAPS_Y][TAPS_X];
    logic signed [PW-1:0] fin_src [CHANNELS][TAPS_Y][TAPS_X];
    logic signed [PW:0]   acc     [CHANNELS][TAPS_Y][TAPS_X];
    logic signed [PW:0]   shv     [CHANNELS][TAPS_Y][TAPS_X];
    logic signed [OW-1:0] sat_val [CHANNELS][TAPS_Y][TAPS_X];
    logic [CHANNELS-1:0]  sat_flag;
    logic [CHANNELS-1:0]  sat_reg;

    // A stage moves on when the output fires or any later stage has a hole;
    // the oldest beat is never blocked by anything but the output port.
    always_comb begin
        adv = '0;
        for (int i = 0; i < MS; i++) begin
            adv[i] = valid[i] && !clr &&
                     (out_ready || (|(~valid >> (i + 1))));
        end
    end

    assign in_ready  = !clr && (!valid[0] || adv[0]);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = valid[MS-1];
    assign out_sat   = sat_reg & {CHANNELS{valid[MS-1]}};

    // Per-stage load enable and the valid bit offered from upstream.
    always_comb begin
        load = '0;
        up   = '0;
        for (int i = 0; i < MS; i++) begin
            load[i] = !valid[i] || adv[i];
            up[i]   = (i == 0) ? in_fire : adv[(i == 0) ? 0 : i - 1];
        end
    end

    // Valid bits: async reset, flush on clr, else refill from upstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (clr) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < MS; i++) begin
                if (load[i]) valid[i] <= up[i];
            end
        end
    end

    // Signed weight times zero-extended colour, full precision.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            for (int y = 0; y < TAPS_Y; y++) begin
                for (int x = 0; x < TAPS_X; x++) begin
                    prod[c][y][x] = PW'(weights_matrix[y][x]) *
                        {{(PW - COLOR_WIDTH){1'b0}}, texel_matrix[c][y][x]};
                end
            end
        end
    end

    if (MS == 1) begin : g_single
        // Single stage: multiply and post-process in the same register.
        always_comb begin
            fin_src  = prod;
            fin_load = in_fire;
        end
    end else begin : g_multi
        logic signed [PW-1:0] pipe [MS-1][CHANNELS][TAPS_Y][TAPS_X];

        // Product registers; data has no reset and only moves with a beat.
        always_ff @(posedge clk) begin
            if (in_fire) pipe[0] <= prod;
            for (int s = 1; s < MS - 1; s++) begin
                if (adv[s-1]) pipe[s] <= pipe[s-1];
            end
        end

        // Last product register feeds the output stage.
        always_comb begin
            fin_src  = pipe[MS-2];
            fin_load = adv[MS-2];
        end
    end

    // Round, arithmetic shift and clamp each element into the result width.
    always_comb begin
        sat_flag = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int y = 0; y < TAPS_Y; y++) begin
                for (int x = 0; x < TAPS_X; x++) begin
                    acc[c][y][x] = {fin_src[c][y][x][PW-1], fin_src[c][y][x]}
                                   + BIAS;
                    shv[c][y][x] = acc[c][y][x] >>> SHIFT;
                    if (shv[c][y][x] > SAT_MAX) begin
                        sat_val[c][y][x] = SAT_MAX[OW-1:0];
                        sat_flag[c]      = 1'b1;
                    end else if (shv[c][y][x] < SAT_MIN) begin
                        sat_val[c][y][x] = SAT_MIN[OW-1:0];
                        sat_flag[c]      = 1'b1;
                    end else begin
                        sat_val[c][y][x] = shv[c][y][x][OW-1:0];
                    end
                end
            end
        end
    end

    // Output stage registers; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (fin_load) begin
            weighted_texel_matrix <= sat_val;
            sat_reg               <= sat_flag;
        end
    end

endmodule

// File: tb/tb_dc_ipu_filter_core_s0_mc.sv
// Bench: two instances (defaults, and ROUND=1 with 10-bit results) share
// stimulus; a queue scoreboard checks every presented beat against a model.
module tb_dc_ipu_filter_core_s0_mc;

    localparam int D = 256;

    logic clk = 1'b0;
    logic reset, clr, in_valid, out_ready;
    logic ir0, ir1, ov0, ov1;
    logic signed [11:0] w [4][4];
    logic [7:0] t [3][4][4];
    logic signed [11:0] wtm0 [3][4][4];
    logic signed [9:0] wtm1 [3][4][4];
    logic [2:0] sat0, sat1;

    typedef struct {
        int v0 [3][4][4];
        int v1 [3][4][4];
        logic [2:0] s0;
        logic [2:0] s1;
        int acc;
    } exp_t;

    exp_t q[$];
    exp_t ent;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit exp_ov, exp_ir, okd, sb;
    longint ad, ed;

    always #5 clk = ~clk;

    dc_ipu_filter_core_s0_mc dut0 (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_ready(ir0),
        .weights_matrix(w), .texel_matrix(t),
        .out_valid(ov0), .out_ready(out_ready),
        .weighted_texel_matrix(wtm0), .out_sat(sat0)
    );

    dc_ipu_filter_core_s0_mc #(
        .WEIGHTED_COLOR_WIDTH(10), .ROUND(1)
    ) dut1 (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_ready(ir1),
        .weights_matrix(w), .texel_matrix(t),
        .out_valid(ov1), .out_ready(out_ready),
        .weighted_texel_matrix(wtm1), .out_sat(sat1)
    );

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Value = floor(w*c [+ half LSB] / 2^8), clamped to ow-bit signed.
    function automatic longint model(input longint wv, input longint cv,
                                     input bit rnd, input int ow,
                                     output bit sat);
        longint p, r, lim;
        p = wv * cv;
        if (rnd) p = p + D / 2;
        r = p / D;
        if (r * D > p) r = r - 1;
        lim = longint'(1) << (ow - 1);
        sat = 1'b1;
        if (r > lim - 1) return lim - 1;
        if (r < -lim) return -lim;
        sat = 1'b0;
        return r;
    endfunction

    task automatic rand_data();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) begin
                w[y][x] = 12'($urandom);
                for (int c = 0; c < 3; c++) t[c][y][x] = 8'($urandom);
            end
    endtask

    task automatic set_all(input int wv, input int c0, input int c1,
                           input int c2);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) begin
                w[y][x] = 12'(wv);
                t[0][y][x] = 8'(c0);
                t[1][y][x] = 8'(c1);
                t[2][y][x] = 8'(c2);
            end
    endtask

    task automatic one_beat(input string nm);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk(ov0 == 1'b0, {nm, "_lat1"}, ov0, 0);
        @(posedge clk); #1;
        chk(ov0 == 1'b1, {nm, "_lat2"}, ov0, 1);
    endtask

    // Scoreboard monitor: sample mid-cycle, check then update the queue.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
            chk(ov0 == exp_ov, "out_valid0", ov0, exp_ov);
            chk(ov1 == exp_ov, "out_valid1", ov1, exp_ov);
            exp_ir = !clr && !(q.size() >= 2 && !out_ready);
            chk(ir0 == exp_ir, "in_ready0", ir0, exp_ir);
            chk(ir1 == exp_ir, "in_ready1", ir1, exp_ir);
            if (!ov0) chk(sat0 == 3'b0, "sat_idle0", sat0, 0);
            if (ov0 && q.size() > 0) begin
                okd = 1'b1; ad = 0; ed = 0;
                for (int c = 0; c < 3; c++)
                    for (int y = 0; y < 4; y++)
                        for (int x = 0; x < 4; x++)
                            if (okd && wtm0[c][y][x] != q[0].v0[c][y][x]) begin
                                okd = 1'b0;
                                ad = wtm0[c][y][x];
                                ed = q[0].v0[c][y][x];
                            end
                chk(okd, "data0", ad, ed);
                okd = 1'b1; ad = 0; ed = 0;
                for (int c = 0; c < 3; c++)
                    for (int y = 0; y < 4; y++)
                        for (int x = 0; x < 4; x++)
                            if (okd && wtm1[c][y][x] != q[0].v1[c][y][x]) begin
                                okd = 1'b0;
                                ad = wtm1[c][y][x];
                                ed = q[0].v1[c][y][x];
                            end
                chk(okd, "data1", ad, ed);
                chk(sat0 == q[0].s0, "sat0", sat0, q[0].s0);
                chk(sat1 == q[0].s1, "sat1", sat1, q[0].s1);
            end
            if (clr) begin
                q.delete();
            end else begin
                if (ov0 && out_ready && q.size() > 0) void'(q.pop_front());
                if (in_valid && ir0) begin
                    ent.s0 = '0;
                    ent.s1 = '0;
                    ent.acc = cyc;
                    for (int c = 0; c < 3; c++)
                        for (int y = 0; y < 4; y++)
                            for (int x = 0; x < 4; x++) begin
                                ent.v0[c][y][x] = int'(model(w[y][x],
                                    t[c][y][x], 1'b0, 12, sb));
                                if (sb) ent.s0[c] = 1'b1;
                                ent.v1[c][y][x] = int'(model(w[y][x],
                                    t[c][y][x], 1'b1, 10, sb));
                                if (sb) ent.s1[c] = 1'b1;
                            end
                    q.push_back(ent);
                end
            end
        end
        cyc++;
    end

    initial begin
        int sent, k;
        bit acc;
        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_all(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk(ov0 == 1'b0, "rst_out_valid", ov0, 0);
        chk(ir0 == 1'b1, "rst_in_ready", ir0, 1);
        chk(sat0 == 3'b0, "rst_out_sat", sat0, 0);
        @(posedge clk); #1;

        set_all(1024, 200, 200, 200);
        one_beat("unity");
        chk(wtm0[0][0][0] == 800, "unity_e000", wtm0[0][0][0], 800);
        chk(wtm0[2][3][3] == 800, "unity_e233", wtm0[2][3][3], 800);
        chk(sat0 == 3'b000, "unity_sat", sat0, 0);

        set_all(-512, 255, 255, 255);
        one_beat("neg");
        chk(wtm0[1][2][3] == -510, "neg_e123", wtm0[1][2][3], -510);

        set_all(1, 128, 128, 128);
        one_beat("round");
        chk(wtm0[0][1][1] == 0, "trunc_e011", wtm0[0][1][1], 0);
        chk(wtm1[0][1][1] == 1, "round_e011", wtm1[0][1][1], 1);

        set_all(1024, 0, 200, 0);
        one_beat("sat");
        chk(wtm1[1][0][2] == 511, "sat_e102", wtm1[1][0][2], 511);
        chk(wtm1[0][0][0] == 0, "sat_e000", wtm1[0][0][0], 0);
        chk(sat1 == 3'b010, "sat_flags", sat1, 2);
        chk(sat0 == 3'b000, "nosat_flags", sat0, 0);

        sent = 0; k = 0;
        rand_data();
        in_valid = 1'b1;
        while (sent < 8 && k < 200) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            @(negedge clk) acc = ir0;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                rand_data();
            end
            k++;
        end
        in_valid = 1'b0;
        chk(sent == 8, "stream_sent", sent, 8);
        repeat (3) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            k++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        out_ready = 1'b0;
        rand_data(); in_valid = 1'b1;
        @(posedge clk); #1;
        rand_data();
        @(posedge clk); #1;
        chk(ir0 == 1'b0, "full_stall", ir0, 0);
        clr = 1'b1; out_ready = 1'b1; rand_data();
        #1;
        chk(ir0 == 1'b0, "clr_ready", ir0, 0);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        chk(ov0 == 1'b0, "clr_flush", ov0, 0);
        @(posedge clk); #1;
        chk(ov0 == 1'b0, "clr_noacc", ov0, 0);

        rand_data(); in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            rand_data();
        end
        #3 reset = 1'b1;
        in_valid = 1'b0;
        #1;
        chk(ov0 == 1'b0, "rst_async", ov0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rand_data();
        chk(ir0 == 1'b1, "rst_release_ready", ir0, 1);
        one_beat("rst_first");

        repeat (300) begin
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 39) == 0);
            rand_data();
            @(posedge clk); #1;
        end
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk(q.size() == 0, "drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dc_ipu_filter_core_s0_mc.md
DC_IPU_FILTER_CORE_S0_MC -- requirements
Module: dc_ipu_filter_core_s0_mc

Interface
REQ-001 SHALL have parameter TAPS_Y, default 4: kernel rows.
REQ-002 SHALL have parameter TAPS_X, default 4: kernel columns.
REQ-003 SHALL have parameter CHANNELS, default 3: colour channels per texel; all channels share one weight matrix.
REQ-004 SHALL have parameter WEIGHT_WIDTH, default 12: signed weight width.
REQ-005 SHALL have parameter WEIGHT_FRACT_WIDTH, default 10: weight fractional bits.
REQ-006 SHALL have parameter COLOR_WIDTH, default 8: unsigned colour width.
REQ-007 SHALL have parameter WEIGHTED_COLOR_WIDTH, default 12: signed result width.
REQ-008 SHALL have parameter WEIGHTED_COLOR_FRACT_WIDTH, default 2: result fractional bits; SHIFT = WEIGHT_FRACT_WIDTH - WEIGHTED_COLOR_FRACT_WIDTH, and SHIFT < 0 SHALL be a compile-time error.
REQ-009 SHALL have parameter MUL_STAGES, default 2, range 1..4: pipeline register stages.
REQ-010 SHALL have parameter ROUND, default 0: 0 = truncate, 1 = round half up.
REQ-011 SHALL have port clk, input, 1 bit: single clock; all flops on rising edge.
REQ-012 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-013 SHALL have port clr, input, 1 bit: synchronous pipeline flush.
REQ-014 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-015 SHALL have port weights_matrix, input, signed WEIGHT_WIDTH, array [TAPS_Y][TAPS_X].
REQ-016 SHALL have port texel_matrix, input, COLOR_WIDTH, array [CHANNELS][TAPS_Y][TAPS_X].
REQ-017 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-018 SHALL have port weighted_texel_matrix, output, signed WEIGHTED_COLOR_WIDTH, array [CHANNELS][TAPS_Y][TAPS_X].
REQ-019 SHALL have port out_sat, output, CHANNELS bits: per-channel flag, set if any element of that channel saturated in the presented beat.

Function
REQ-020 SHALL accept a beat when in_valid && in_ready, and present it when out_valid && out_ready.
REQ-021 SHALL implement MUL_STAGES stages, each with one valid bit; a stage SHALL load when it is empty or its downstream stage advances in the same cycle, so bubbles collapse.
REQ-022 SHALL drive in_ready = !valid[0] || advance[0], combinationally, with no dependency on in_valid.
REQ-023 SHALL give a latency of exactly MUL_STAGES cycles from acceptance to out_valid when out_ready is held high, sustaining one beat per cycle.
REQ-024 SHALL hold weighted_texel_matrix and out_sat stable while out_valid && !out_ready.
REQ-025 SHALL compute each product as the signed weight times the zero-extended colour, into signed WEIGHT_WIDTH+COLOR_WIDTH+1 bits.
REQ-026 SHALL, when ROUND=1 and SHIFT>0, add 2^(SHIFT-1) before an arithmetic right shift by SHIFT; ROUND=0 SHALL shift only.
REQ-027 SHALL saturate the shifted value to [-2^(W-1), 2^(W-1)-1], where W = WEIGHTED_COLOR_WIDTH, and raise the matching out_sat bit.
REQ-028 SHALL perform the multiply in stage 0 and the round/shift/saturate in the final stage; when MUL_STAGES=1, both SHALL occur in one stage.
REQ-029 SHALL clear all valid bits on the next edge when clr=1, without changing data registers; in_ready SHALL be 0 during that cycle, and a simultaneous input beat SHALL NOT be accepted.
REQ-030 SHALL give clr priority over both handshakes in the same cycle; the output beat is dropped even if out_ready=1.
REQ-031 SHALL keep out_valid=0 when in_valid=0, with no spurious beats.

Reset
REQ-032 SHALL, while reset=1, asynchronously clear every valid bit, giving out_valid=0, out_sat=0 and in_ready=1 after reset is released.
REQ-033 SHALL leave data registers without reset; weighted_texel_matrix is don't-care while out_valid=0.
REQ-034 SHALL discard all in-flight beats on reset asserted mid-operation, and SHALL accept the first beat in the cycle after release.

Verification
REQ-035 Defaults, ROUND=0; all weights 1024, all colours 200, out_ready=1 -> out_valid 2 cycles later; all elements = 800; out_sat=0.
REQ-036 Defaults; weight -512, colour 255 -> element = -510.
REQ-037 ROUND=1 vs ROUND=0; weight 1, colour 128 -> 1 vs 0.
REQ-038 WEIGHTED_COLOR_WIDTH=10; weight 1024, colour 200 on channel 1 only -> channel 1 elements = 511, out_sat=3'b010.
REQ-039 Stream 8 beats while toggling out_ready 1,0,0,1,... -> in-order delivery; no loss or duplication; outputs stable while stalled; in_ready=0 only when full and stalled.
REQ-040 Pipeline full with clr=1 and in_valid=1 in the same cycle -> next cycle out_valid=0 and no beat accepted; repeat with reset mid-stream -> same result, and the first beat after release appears 2 cycles later.
